// File: rtl/sopc_cpu_oci_trace_capture.sv
// ============================================================================
// Module : sopc_cpu_oci_trace_capture
// Desc   : Captures debug-core trace frames into a FIFO read through a
//          valid/ready port; drains at end of test and flags completion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sopc_cpu_oci_trace_capture #(
    parameter int FRAME_W   = 30,
    parameter int COUNT_W   = 4,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int WRAP_MODE = 0,
    parameter int OVF_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               capture_en,
    input  logic               dct_valid,
    input  logic [FRAME_W-1:0] dct_buffer,
    input  logic [COUNT_W-1:0] dct_count,
    input  logic               test_ending,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAME_W-1:0] out_frame,
    output logic [COUNT_W-1:0] out_count,
    output logic [AW:0]        level,
    output logic [OVF_W-1:0]   overflow_cnt,
    output logic               test_has_ended
);

    localparam logic [1:0]       c_st_capture = 2'd0;
    localparam logic [1:0]       c_st_drain   = 2'd1;
    localparam logic [1:0]       c_st_ended   = 2'd2;
    localparam int               c_entry_w    = FRAME_W + COUNT_W;
    localparam logic [AW:0]      c_depth      = (AW+1)'(DEPTH);
    localparam logic [AW:0]      c_lvl_one    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0]    c_ptr_one    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [OVF_W-1:0] c_ovf_one    = {{(OVF_W-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_level;
    logic [AW:0]          w_level_next;
    logic [OVF_W-1:0]     r_ovf;
    logic [c_entry_w-1:0] r_mem [DEPTH];
    logic [c_entry_w-1:0] w_head;

    logic w_capture;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_wrap;
    logic w_write;
    logic w_ovf_inc;
    logic w_rd_adv;

    generate
        if (WRAP_MODE != 0) begin : g_wrap_overwrite
            assign w_wrap = 1'b1;
        end else begin : g_wrap_drop
            assign w_wrap = 1'b0;
        end
    endgenerate

    assign w_push    = w_capture & capture_en & dct_valid & (dct_count != '0);
    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid & out_ready;
    assign w_full    = (r_level == c_depth);

    // When full and not popping, the frame is either dropped or overwrites the oldest.
    assign w_write   = w_push & (~w_full | w_pop | w_wrap);
    assign w_ovf_inc = w_push & w_full & ~w_pop;
    assign w_rd_adv  = w_pop | (w_ovf_inc & w_wrap);

    always_comb begin
        w_level_next = r_level;
        if (w_write && !w_rd_adv) begin
            w_level_next = r_level + c_lvl_one;
        end else if (!w_write && w_rd_adv) begin
            w_level_next = r_level - c_lvl_one;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_capture;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_capture: if (test_ending) w_state_next = c_st_drain;
            c_st_drain:   if (w_level_next == '0) w_state_next = c_st_ended;
            c_st_ended:   w_state_next = c_st_ended;
            default:      w_state_next = c_st_capture;
        endcase
    end

    always_comb begin
        w_capture      = (r_state == c_st_capture);
        test_has_ended = (r_state == c_st_ended);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= '0;
        end else begin
            r_level <= w_level_next;
            if (w_write) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_rd_adv) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (w_ovf_inc && (r_ovf != '1)) begin
                r_ovf <= r_ovf + c_ovf_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wptr] <= {dct_buffer, dct_count};
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign w_head       = r_mem[r_rptr];
    assign out_frame    = out_valid ? w_head[c_entry_w-1:COUNT_W] : '0;
    assign out_count    = out_valid ? w_head[COUNT_W-1:0] : '0;
    assign level        = r_level;
    assign overflow_cnt = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sopc_cpu_oci_trace_capture.sv
// ============================================================================
// Module : tb_sopc_cpu_oci_trace_capture
// Desc   : Scoreboard bench driving a drop-mode and an overwrite-mode
//          instance with identical directed stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sopc_cpu_oci_trace_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        capture_en;
    logic        dct_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        out_ready;

    logic        ov0, ov1;
    logic [29:0] of0, of1;
    logic [3:0]  oc0, oc1;
    logic [4:0]  lv0, lv1;
    logic [15:0] ovf0, ovf1;
    logic        th0, th1;

    logic [33:0] q0[$];
    logic [33:0] q1[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          accepting;

    always #5 clk = ~clk;

    sopc_cpu_oci_trace_capture #(.WRAP_MODE(0)) u_dut_drop (
        .clk(clk), .reset_n(reset_n), .capture_en(capture_en), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .out_valid(ov0), .out_ready(out_ready), .out_frame(of0), .out_count(oc0),
        .level(lv0), .overflow_cnt(ovf0), .test_has_ended(th0)
    );

    sopc_cpu_oci_trace_capture #(.WRAP_MODE(1)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .capture_en(capture_en), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .out_valid(ov1), .out_ready(out_ready), .out_frame(of1), .out_count(oc1),
        .level(lv1), .overflow_cnt(ovf1), .test_has_ended(th1)
    );

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // A pop happens at the next rising edge; compare the head against the queue front.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_ready === 1'b1 && ov0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drop_extra_pop: actual %0h required none", {of0, oc0});
            end else begin
                check("drop_pop_order", {of0, oc0}, q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_ready === 1'b1 && ov1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wrap_extra_pop: actual %0h required none", {of1, oc1});
            end else begin
                check("wrap_pop_order", {of1, oc1}, q1.pop_front());
            end
        end
    end

    task automatic drive(input bit v, input logic [29:0] f, input logic [3:0] c,
                         input bit te, input bit rdy);
        dct_valid   = v;
        dct_buffer  = f;
        dct_count   = c;
        test_ending = te;
        out_ready   = rdy;
        if (v && accepting && capture_en && c != 4'd0) begin
            if (q0.size() < 16 || (rdy && q0.size() != 0)) q0.push_back({f, c});
            if (q1.size() < 16 || (rdy && q1.size() != 0)) begin
                q1.push_back({f, c});
            end else begin
                void'(q1.pop_front());
                q1.push_back({f, c});
            end
        end
        if (te) accepting = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        capture_en  = 1'b1;
        dct_valid   = 1'b0;
        dct_buffer  = '0;
        dct_count   = '0;
        test_ending = 1'b0;
        out_ready   = 1'b0;
        accepting   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", 34'(lv0), 34'd0);
        check("rst_valid", 34'(ov0), 34'd0);
        check("rst_ovf", 34'(ovf0), 34'd0);
        check("rst_ended", 34'(th0), 34'd0);
        check("rst_head", {of0, oc0}, 34'd0);
        reset_n = 1'b1;

        // In-order push then drain
        drive(1, 30'h1, 4'h1, 0, 0);
        drive(1, 30'h2, 4'h2, 0, 0);
        drive(1, 30'h3, 4'h3, 0, 0);
        check("t1_level", 34'(lv0), 34'd3);
        check("t1_head", {of0, oc0}, {30'h1, 4'h1});
        repeat (3) drive(0, 30'h0, 4'h0, 0, 1);
        check("t1_level_end", 34'(lv0), 34'd0);
        check("t1_valid_end", 34'(ov0), 34'd0);

        // Overfill with 20 frames, no pops
        for (int i = 1; i <= 20; i++) drive(1, 30'(i), 4'((i % 15) + 1), 0, 0);
        check("t2_drop_level", 34'(lv0), 34'd16);
        check("t2_drop_ovf", 34'(ovf0), 34'd4);
        check("t2_drop_head", {of0, oc0}, {30'd1, 4'd2});
        check("t3_wrap_level", 34'(lv1), 34'd16);
        check("t3_wrap_ovf", 34'(ovf1), 34'd4);
        check("t3_wrap_head", {of1, oc1}, {30'd5, 4'd6});

        // Full with push and pop together
        drive(1, 30'h21, 4'h5, 0, 1);
        check("t4_drop_level", 34'(lv0), 34'd16);
        check("t4_drop_ovf", 34'(ovf0), 34'd4);
        check("t4_wrap_level", 34'(lv1), 34'd16);
        check("t4_wrap_ovf", 34'(ovf1), 34'd4);
        repeat (15) drive(0, 30'h0, 4'h0, 0, 1);
        check("t4_drop_newest", {of0, oc0}, {30'h21, 4'h5});
        check("t4_wrap_newest", {of1, oc1}, {30'h21, 4'h5});
        drive(0, 30'h0, 4'h0, 0, 1);
        check("t4_drop_empty", 34'(lv0), 34'd0);
        check("t4_wrap_empty", 34'(lv1), 34'd0);

        // Reset in the middle of a drain
        for (int i = 0; i < 7; i++) drive(1, 30'h300 + 30'(i), 4'h7, 0, 0);
        drive(0, 30'h0, 4'h0, 1, 0);
        drive(1, 30'h3FF, 4'h2, 0, 0);
        check("t6_level_drain", 34'(lv0), 34'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_level", 34'(lv0), 34'd0);
        check("t6_rst_valid", 34'(ov0), 34'd0);
        check("t6_rst_ended", 34'(th0), 34'd0);
        check("t6_rst_ovf", 34'(ovf0), 34'd0);
        check("t6_rst_wrap_ovf", 34'(ovf1), 34'd0);
        q0.delete();
        q1.delete();
        accepting = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(1, 30'h5, 4'h0, 0, 0);
        check("t6_zero_count", 34'(lv0), 34'd0);
        check("t6_zero_ovf", 34'(ovf0), 34'd0);

        // End-of-test with a simultaneous frame
        for (int i = 0; i < 5; i++) drive(1, 30'h100 + 30'(i), 4'(i + 1), 0, 0);
        drive(1, 30'h1FF, 4'hF, 1, 0);
        drive(1, 30'h2AA, 4'h3, 0, 0);
        drive(1, 30'h2AB, 4'h3, 0, 0);
        check("t5_level", 34'(lv0), 34'd6);
        check("t5_not_ended", 34'(th0), 34'd0);
        repeat (5) drive(0, 30'h0, 4'h0, 0, 1);
        check("t5_level_one", 34'(lv0), 34'd1);
        check("t5_still_drain", 34'(th0), 34'd0);
        drive(0, 30'h0, 4'h0, 0, 1);
        check("t5_level_zero", 34'(lv0), 34'd0);
        check("t5_ended", 34'(th0), 34'd1);
        check("t5_wrap_ended", 34'(th1), 34'd1);
        repeat (3) drive(1, 30'h77, 4'h1, 1, 0);
        check("t5_sticky", 34'(th0), 34'd1);
        check("t5_no_push_ended", 34'(lv0), 34'd0);
        check("q0_drained", 34'(q0.size()), 34'd0);
        check("q1_drained", 34'(q1.size()), 34'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sopc_cpu_oci_trace_capture.md
Name: sopc_cpu_oci_trace_capture

Overview:
Parametrised successor to the OCI test-bench monitor. It captures Nios II debug-core trace (DCT) frames into an on-chip FIFO and presents them on a valid/ready read port. It handles end-of-test draining and signals completion. It sits beside the CPU OCI in simulation and debug builds, consuming the same dct_buffer/dct_count/test_ending signals and generating test_has_ended itself.

Parameters:
FRAME_W, 30, width of dct_buffer
COUNT_W, 4, width of dct_count
DEPTH, 16, FIFO entries; power of two, >= 2
AW, 4, log2(DEPTH)
WRAP_MODE, 0, 0 = drop newest when full; 1 = overwrite oldest
OVF_W, 16, width of the overflow counter

Ports:
clk  in  1  system clock; all state changes on its rising edge
reset_n  in  1  asynchronous active-low reset
capture_en  in  1  enables frame capture while in CAPTURE
dct_valid  in  1  dct_buffer/dct_count hold a frame this cycle
dct_buffer  in  FRAME_W  trace frame payload
dct_count  in  COUNT_W  number of valid trace slots in the frame
test_ending  in  1  end-of-test request; level or pulse
out_valid  out  1  FIFO head is available
out_ready  in  1  consumer accepts the head this cycle
out_frame  out  FRAME_W  payload of the head entry
out_count  out  COUNT_W  count of the head entry
level  out  AW+1  current number of entries, 0..DEPTH
overflow_cnt  out  OVF_W  frames lost or overwritten; saturating
test_has_ended  out  1  drain complete; sticky

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State = CAPTURE.
  - Pointers cleared.
  - level=0, out_valid=0, overflow_cnt=0, test_has_ended=0.
  - out_frame and out_count read 0 while empty.
- Push condition: state==CAPTURE, capture_en=1, dct_valid=1, dct_count!=0.
  - Frames with dct_count==0 are ignored and not counted as overflow.
- Pop condition: out_valid & out_ready.
- out_valid = (level!=0). The head is visible combinationally from the memory/registers.
  - A frame pushed at edge N is visible with out_valid=1 after edge N.
- level update per edge:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop occur together.
- Full (level==DEPTH) with push and no pop:
  - WRAP_MODE=0: frame dropped, overflow_cnt+1.
  - WRAP_MODE=1: frame written at the write pointer, read pointer advances (oldest lost), level stays DEPTH, overflow_cnt+1.
- Full with push and pop together: normal push/pop, no overflow.
- Empty with push and pop together: impossible, since out_valid=0.
- overflow_cnt saturates at all-ones.
- Pointers are AW bits and wrap modulo DEPTH.
- State machine:
  - CAPTURE -> DRAIN when test_ending=1. A push qualifying in that same cycle is still accepted.
  - DRAIN: no pushes regardless of dct_valid; pops continue.
  - DRAIN -> ENDED on the edge where the level becomes 0. If level is already 0 on entry, DRAIN lasts exactly one cycle.
  - ENDED: test_has_ended=1 (registered); no pushes; held until reset. test_ending is ignored outside CAPTURE.
- capture_en=0 in CAPTURE blocks pushes but does not block test_ending handling.
- Reset mid-operation: all contents discarded, and all outputs return to reset values immediately.

Test Plan:
- Push 3 frames (0x0000_0001/1, 0x0000_0002/2, 0x0000_0003/3) with out_ready=0 -> level=3, head=0x1/1. Then out_ready=1 for 3 cycles -> frames are output in order and level=0.
- WRAP_MODE=0, DEPTH=16: push 20 frames 1..20 with no pops -> level=16, overflow_cnt=4, drain yields 1..16.
- WRAP_MODE=1, same stimulus -> level=16, overflow_cnt=4, drain yields 5..20.
- Full FIFO with push and pop in the same cycle -> level stays 16, overflow_cnt unchanged, newest frame retained.
- 5 entries queued, test_ending pulse with a simultaneous valid frame -> frame accepted (level=6), later dct_valid ignored. After 6 pops, test_has_ended=1 on the following edge and stays set.
- reset_n low mid-drain with level=7 -> level=0, out_valid=0, test_has_ended=0, overflow_cnt=0 immediately. A frame with dct_count=0 afterwards leaves level=0.
